// File: rtl/secure_platform_ri5cy.sv
// UART-controlled platform shell: 8N1 receiver, packet parser (loopback / boot / scanf),
// loopback transmitter and LED status display.
module secure_platform_ri5cy #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NOC_ADDR     = 8,
  parameter int BUF_DEPTH    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fetch_enable,
  input  logic       BT_RX,
  output logic       BT_TX,
  output logic [7:0] output_LEDS
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int MW = AW + 1;
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] DEPTH    = 16'(BUF_DEPTH);
  localparam logic [7:0]  MY_ADDR  = 8'(NOC_ADDR);
  localparam logic [MW-1:0] LB_BASE = '0;

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] P_HDR = 3'd0, P_ADDR = 3'd1, P_SZLO = 3'd2, P_SZHI = 3'd3,
                         P_PAY = 3'd4;
  localparam logic [7:0] H_LOOP = 8'h00, H_BOOT = 8'h01, H_SCANF = 8'h03;

  logic        rx_meta, rx_sync, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_valid, rx_ferr;

  logic [2:0]  p_state;
  logic [7:0]  hdr;
  logic        addr_ok, lb_drop;
  logic [15:0] size, idx;
  logic        err, boot_loaded, run, tx_start;
  logic [3:0]  pkt_count;
  logic [7:0]  scanf_reg;
  // Lower half holds the loopback buffer, upper half the boot buffer.
  logic [7:0]  buf_mem [2*BUF_DEPTH];

  logic        tx_active;
  logic [9:0]  tx_frame;
  logic [15:0] tx_cnt, tx_idx, tx_len, tx_nxt;
  logic [3:0]  tx_bit;

  logic accept, known, tx_busy;
  assign accept  = addr_ok & ~lb_drop;
  assign known   = (hdr == H_LOOP) || (hdr == H_BOOT) || (hdr == H_SCANF);
  assign tx_busy = tx_active | tx_start;
  assign tx_nxt  = tx_idx + 16'd1;

  // Receiver: synchronize, detect falling edge, sample mid-bit, flag good byte or framing error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b0;
      rx_sync  <= 1'b0;
      rx_prev  <= 1'b0;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= BT_RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A glitch that is high again at mid-bit is not a start bit.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_state <= RX_IDLE;
            if (rx_sync) rx_valid <= 1'b1;
            else         rx_ferr  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Packet parser: frame packets by size, fill buffers, update status and trigger loopback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_state     <= P_HDR;
      hdr         <= '0;
      addr_ok     <= 1'b0;
      lb_drop     <= 1'b0;
      size        <= '0;
      idx         <= '0;
      err         <= 1'b0;
      boot_loaded <= 1'b0;
      run         <= 1'b0;
      tx_start    <= 1'b0;
      pkt_count   <= '0;
      scanf_reg   <= '0;
      for (int i = 0; i < 2 * BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      tx_start <= 1'b0;
      if (fetch_enable) run <= 1'b1;
      if (rx_ferr) err <= 1'b1;
      if (rx_valid) begin
        case (p_state)
          P_HDR: begin
            hdr     <= rx_shift;
            p_state <= P_ADDR;
          end
          P_ADDR: begin
            addr_ok <= (rx_shift == MY_ADDR);
            lb_drop <= (rx_shift == MY_ADDR) && (hdr == H_LOOP) && tx_busy;
            // Foreign packets never touch err.
            if (rx_shift == MY_ADDR && (!known || (hdr == H_LOOP && tx_busy))) err <= 1'b1;
            p_state <= P_SZLO;
          end
          P_SZLO: begin
            size[7:0] <= rx_shift;
            p_state   <= P_SZHI;
          end
          P_SZHI: begin
            size[15:8] <= rx_shift;
            idx        <= '0;
            if ({rx_shift, size[7:0]} == 16'd0) begin
              if (accept) pkt_count <= pkt_count + 4'd1;
              p_state <= P_HDR;
            end else begin
              p_state <= P_PAY;
            end
          end
          default: begin
            if (idx < DEPTH) begin
              if (accept && hdr == H_LOOP) buf_mem[{1'b0, idx[AW-1:0]}] <= rx_shift;
              if (accept && hdr == H_BOOT) buf_mem[{1'b1, idx[AW-1:0]}] <= rx_shift;
            end else if (accept && (hdr == H_LOOP || hdr == H_BOOT)) begin
              err <= 1'b1;
            end
            idx <= idx + 16'd1;
            if (idx == size - 16'd1) begin
              p_state <= P_HDR;
              if (accept) begin
                pkt_count <= pkt_count + 4'd1;
                if (hdr == H_BOOT)  boot_loaded <= 1'b1;
                if (hdr == H_SCANF) scanf_reg   <= rx_shift;
                if (hdr == H_LOOP)  tx_start    <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // Loopback transmitter: send buffered bytes as back-to-back 8N1 frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_active <= 1'b0;
      tx_frame  <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_idx    <= '0;
      tx_len    <= '0;
    end else if (tx_start) begin
      tx_active <= 1'b1;
      tx_frame  <= {1'b1, buf_mem[LB_BASE], 1'b0};
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_idx    <= '0;
      tx_len    <= (size > DEPTH) ? DEPTH : size;
    end else if (tx_active) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_bit <= '0;
          if (tx_nxt == tx_len) begin
            tx_active <= 1'b0;
          end else begin
            tx_idx   <= tx_nxt;
            tx_frame <= {1'b1, buf_mem[{1'b0, tx_nxt[AW-1:0]}], 1'b0};
          end
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // Line and LED outputs derive directly from registers.
  always_comb begin
    BT_TX       = tx_active ? tx_frame[0] : 1'b1;
    output_LEDS = run ? scanf_reg : {1'b0, boot_loaded, err, 1'b0, pkt_count};
  end

endmodule

// File: tb/tb_secure_platform_ri5cy.sv
// Bench for secure_platform_ri5cy: directed and randomized packets against a packet-level model.
module tb_secure_platform_ri5cy;
  localparam int CPB   = 16;  // short bit time keeps the run small
  localparam int DEPTH = 8;   // small buffers make overflow cheap to reach
  localparam int NADDR = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fetch_enable = 1'b0;
  logic       BT_RX = 1'b1;
  logic       BT_TX;
  logic [7:0] output_LEDS;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_stop = 0;

  // Model state
  bit         m_err, m_boot, m_run;
  bit [3:0]   m_cnt;
  logic [7:0] m_scanf;
  logic [7:0] m_bbuf [DEPTH];
  logic [7:0] exp_tx [$];
  logic [7:0] tx_got [$];
  int         tx_t [$];
  logic [7:0] pl [$];

  int         mt;
  logic [7:0] mb;

  secure_platform_ri5cy #(
    .CLKS_PER_BIT(CPB),
    .NOC_ADDR    (NADDR),
    .BUF_DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_enable(fetch_enable),
    .BT_RX       (BT_RX),
    .BT_TX       (BT_TX),
    .output_LEDS (output_LEDS)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_clear();
    m_err = 0; m_boot = 0; m_run = 0; m_cnt = 0; m_scanf = 0;
    for (int i = 0; i < DEPTH; i++) m_bbuf[i] = 0;
    exp_tx.delete(); tx_got.delete(); tx_t.delete();
  endtask

  task automatic do_reset();
    reset = 0; BT_RX = 1; fetch_enable = 0;
    tick(2);
    reset = 1;
    model_clear();
    tick(2);
  endtask

  task automatic fetch_pulse();
    fetch_enable = 1;
    tick(1);
    fetch_enable = 0;
    m_run = 1;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    BT_RX = 0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      BT_RX = b[i];
      tick(CPB);
    end
    last_stop = cyc;
    BT_RX = stop_bit;
    tick(CPB);
    BT_RX = 1;
    tick($urandom_range(0, 2));
  endtask

  task automatic send_packet(input logic [7:0] h, input logic [7:0] a);
    int n;
    n = pl.size();
    send_byte(h, 1);
    send_byte(a, 1);
    send_byte(n[7:0], 1);
    send_byte(n[15:8], 1);
    foreach (pl[i]) send_byte(pl[i], 1);
  endtask

  // Packet-level effect of one packet whose payload is pl.
  task automatic model_pkt(input logic [7:0] h, input logic [7:0] a, input bit busy);
    int n;
    n = pl.size();
    if (a != NADDR) return;
    if (h == 8'h00 && busy) begin
      m_err = 1;
      return;
    end
    if (!(h == 8'h00 || h == 8'h01 || h == 8'h03)) m_err = 1;
    if ((h == 8'h00 || h == 8'h01) && n > DEPTH) m_err = 1;
    m_cnt++;
    if (h == 8'h00) for (int i = 0; i < n && i < DEPTH; i++) exp_tx.push_back(pl[i]);
    if (h == 8'h01) begin
      if (n > 0) m_boot = 1;
      for (int i = 0; i < n && i < DEPTH; i++) m_bbuf[i] = pl[i];
    end
    if (h == 8'h03 && n > 0) m_scanf = pl[n-1];
  endtask

  task automatic check_leds(input string tag);
    logic [7:0] e;
    e = m_run ? m_scanf : {1'b0, m_boot, m_err, 1'b0, m_cnt};
    chk(tag, {24'd0, output_LEDS}, {24'd0, e});
  endtask

  task automatic check_boot(input string tag, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), {24'd0, dut.buf_mem[DEPTH + i]}, {24'd0, m_bbuf[i]});
  endtask

  task automatic drain_check(input string tag, input bit chk_lat);
    int lim;
    int n;
    lim = (exp_tx.size() + 2) * 12 * CPB;
    for (int k = 0; k < lim && tx_got.size() < exp_tx.size(); k++) tick(1);
    tick(12 * CPB);
    chk({tag, "_count"}, tx_got.size(), exp_tx.size());
    n = (tx_got.size() < exp_tx.size()) ? tx_got.size() : exp_tx.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, tx_got[i]}, {24'd0, exp_tx[i]});
    for (int i = 1; i < tx_t.size(); i++)
      chk($sformatf("%s_gap%0d", tag, i), tx_t[i] - tx_t[i-1], 10 * CPB);
    if (chk_lat && tx_t.size() > 0)
      chk({tag, "_latency"}, 32'((tx_t[0] - last_stop) inside {[CPB/2 + 4 : CPB/2 + 9]}), 1);
    exp_tx.delete(); tx_got.delete(); tx_t.delete();
  endtask

  // TX line monitor: decode frames and record their start cycle.
  initial begin
    forever begin
      @(negedge BT_TX);
      mt = cyc;
      if (reset) begin
        tick(CPB / 2);
        chk("tx_start_bit", {31'd0, BT_TX}, 0);
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          mb[i] = BT_TX;
        end
        tick(CPB);
        chk("tx_stop_bit", {31'd0, BT_TX}, 1);
        tx_got.push_back(mb);
        tx_t.push_back(mt);
      end
    end
  end

  initial begin
    logic [7:0] h, a;
    int n;
    model_clear();
    tick(2);
    chk("rst_tx", {31'd0, BT_TX}, 1);
    chk("rst_leds", {24'd0, output_LEDS}, 0);
    reset = 1;
    tick(2);
    check_leds("post_rst_leds");
    fetch_pulse();
    check_leds("rst_run_leds");
    do_reset();

    // SCANF packet, LEDs before and after run
    pl = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
    send_packet(8'h03, 8'h08); model_pkt(8'h03, 8'h08, 0);
    tick(8);
    check_leds("scanf_pre");
    fetch_pulse();
    check_leds("scanf_run");
    do_reset();

    // LOOPBACK echo
    pl = '{8'hAA, 8'h55};
    send_packet(8'h00, 8'h08); model_pkt(8'h00, 8'h08, 0);
    drain_check("loop", 1);
    check_leds("loop_leds");
    do_reset();

    // BOOT load
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(8'h01, 8'h08); model_pkt(8'h01, 8'h08, 0);
    tick(8);
    check_leds("boot_leds");
    check_boot("boot_buf", 4);
    do_reset();

    // Foreign address ignored, then SCANF
    pl = '{8'hAB, 8'hCD};
    send_packet(8'h03, 8'h05); model_pkt(8'h03, 8'h05, 0);
    pl = '{8'h7E};
    send_packet(8'h03, 8'h08); model_pkt(8'h03, 8'h08, 0);
    tick(8);
    check_leds("addr_pre");
    fetch_pulse();
    check_leds("addr_run");
    do_reset();

    // Framing error, unknown header, parser resynchronised afterwards
    send_byte(8'h55, 0);
    m_err = 1;
    tick(8);
    check_leds("ferr_leds");
    pl = '{8'h99};
    send_packet(8'h02, 8'h08); model_pkt(8'h02, 8'h08, 0);
    pl = '{8'h3C};
    send_packet(8'h03, 8'h08); model_pkt(8'h03, 8'h08, 0);
    tick(8);
    check_leds("unk_leds");
    do_reset();

    // LOOPBACK arriving while TX still busy is dropped
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_packet(8'h00, 8'h08); model_pkt(8'h00, 8'h08, 0);
    pl = '{8'hE7};
    send_packet(8'h00, 8'h08); model_pkt(8'h00, 8'h08, 1);
    drain_check("busy", 0);
    check_leds("busy_leds");
    do_reset();

    // Overflow beyond buffer depth
    pl.delete();
    for (int i = 0; i < DEPTH + 2; i++) pl.push_back(8'($urandom));
    send_packet(8'h00, 8'h08); model_pkt(8'h00, 8'h08, 0);
    drain_check("ovf_loop", 0);
    check_leds("ovf_loop_leds");
    pl.delete();
    for (int i = 0; i < DEPTH + 1; i++) pl.push_back(8'($urandom));
    send_packet(8'h01, 8'h08); model_pkt(8'h01, 8'h08, 0);
    tick(8);
    check_leds("ovf_boot_leds");
    check_boot("ovf_boot_buf", DEPTH);

    // Size-0 packets of each type; pushes pkt_count through its wrap
    pl.delete();
    for (int i = 0; i < 11; i++) begin
      h = (i % 3 == 0) ? 8'h03 : ((i % 3 == 1) ? 8'h01 : 8'h00);
      send_packet(h, 8'h08); model_pkt(h, 8'h08, 0);
    end
    drain_check("size0", 0);
    check_leds("size0_leds");

    // Randomized packets
    for (int p = 0; p < 8; p++) begin
      case ($urandom_range(0, 4))
        0: h = 8'h00;
        1: h = 8'h01;
        2: h = 8'h03;
        3: h = 8'h02;
        default: h = 8'($urandom_range(4, 255));
      endcase
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(9, 255)) : 8'h08;
      n = $urandom_range(0, DEPTH + 1);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_packet(h, a); model_pkt(h, a, 0);
      drain_check($sformatf("rnd%0d", p), 0);
      check_leds($sformatf("rnd%0d_leds", p));
      if ($urandom_range(0, 3) == 0) begin
        fetch_pulse();
        check_leds($sformatf("rnd%0d_run", p));
      end
    end

    // Reset in the middle of a packet payload byte
    pl = '{8'h5A};
    send_byte(8'h03, 1); send_byte(8'h08, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
    BT_RX = 0;
    tick(CPB);
    BT_RX = 1;
    tick(2 * CPB);
    do_reset();
    check_leds("midrst_leds");
    chk("midrst_tx", {31'd0, BT_TX}, 1);
    pl = '{8'hC3};
    send_packet(8'h03, 8'h08); model_pkt(8'h03, 8'h08, 0);
    tick(8);
    check_leds("midrst_pkt");
    fetch_pulse();
    check_leds("midrst_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secure_platform_ri5cy.md
# secure_platform_ri5cy

Top-level UART-controlled platform shell for the RI5CY secure SoC. It receives framed command packets over a serial line (BT_RX) and routes each by header type: loopback echo on BT_TX, boot-image load into an internal boot buffer, or a "scanf" data byte latched for the LEDs. A `fetch_enable` pulse releases the platform into run state, and `output_LEDS` then displays the latched data.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (115200 baud at 100 MHz).
- NOC_ADDR, 8, packet address this platform accepts.
- BUF_DEPTH, 64, bytes in each of the loopback buffer and the boot buffer.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- fetch_enable  in  1  run request; sampled high on a clock edge sets run.
- BT_RX  in  1  UART receive line, 8N1, idle high.
- BT_TX  out  1  UART transmit line, 8N1, idle high.
- output_LEDS  out  8  status or data display.

## Operation
- RX path:
  - 2-flop synchronizer feeds the receiver.
  - A falling edge starts a byte; the start bit is re-checked at mid-bit and the receiver returns to idle if it is high.
  - 8 data bits are sampled LSB first at mid-bit, then the stop bit.
  - Stop bit = 0: framing error; byte discarded, err set.
- Packet parser states: HDR -> ADDR -> SIZE_LO -> SIZE_HI -> PAYLOAD -> HDR.
  - Size is 16-bit little-endian and counts payload bytes.
  - Size 0: the parser returns to HDR after SIZE_HI.
- Header 0x00 LOOPBACK:
  - Payload is written to the loopback buffer from index 0.
  - After the last byte, payload is retransmitted on BT_TX in order, bytes back-to-back.
- Header 0x01 BOOT:
  - Payload is written to the boot buffer from index 0.
  - boot_loaded is set at packet end if size > 0.
- Header 0x03 SCANF: scanf_reg takes the last payload byte.
- Other headers: err is set; the packet is still framed by its size field and its payload is discarded.
- ADDR ≠ NOC_ADDR: the whole packet is consumed and ignored, err untouched, pkt_count unchanged.
- Payload bytes beyond BUF_DEPTH are dropped and err is set. Parsing continues to the declared size.
- LOOPBACK header while TX is still sending: that packet is discarded and err is set.
- pkt_count (4-bit, wraps 15->0) increments at each completed accepted packet.
- run is set by fetch_enable = 1 and is sticky until reset.
- output_LEDS:
  - run = 0: {1'b0, boot_loaded, err, 1'b0, pkt_count}.
  - run = 1: scanf_reg.
- err and boot_loaded are sticky until reset.
- Reset mid-byte or mid-packet aborts everything; no partial state survives.

## Timing
- Reset values:
  - BT_TX = 1, output_LEDS = 0x00.
  - All registers cleared; parser in HDR, RX/TX idle.
- Received byte is valid 1 cycle after the mid-stop-bit sample.
- Parser updates on the cycle the byte is valid.
- Loopback TX start bit begins ≤ 2 cycles after the last payload byte is valid.
- Each TX bit lasts exactly CLKS_PER_BIT cycles; frame = 10 bits; next start bit immediately follows the stop bit.
- run is set 1 cycle after fetch_enable is sampled high; LEDs update combinationally from registers (same cycle as the register change).
- RX and TX run concurrently and independently.

## Test plan
- Reset: hold reset = 0 for 2 cycles -> BT_TX = 1, output_LEDS = 0x00; a 1-cycle fetch_enable pulse afterwards -> output_LEDS = 0x00 (scanf_reg = 0).
- SCANF packet 03 08 08 00 04 03 02 01 08 07 06 05 at 8680 ns/bit, then fetch_enable pulse:
  - output_LEDS = 0x01 before the pulse (pkt_count = 1).
  - output_LEDS = 0x05 after the pulse.
- LOOPBACK packet 00 08 02 00 AA 55 -> BT_TX emits bytes 0xAA then 0x55, 8N1 frames each 10×868 cycles; output_LEDS = 0x01.
- BOOT packet 01 08 04 00 11 22 33 44 -> boot buffer[0..3] = 11 22 33 44; output_LEDS = 0x41.
- Header 0x03 with address 0x05, size 2, then a valid SCANF packet to 0x08 with payload 0x7E -> output_LEDS = 0x01 before run, 0x7E after run.
- Byte with stop bit = 0 -> err set, output_LEDS[5] = 1; unknown header 0x02 with size 1 -> err set and the parser is back in HDR for the next packet.
